// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte path.
// The queue uses tx_state_e; the baud constants belong to the Receiver/Sender.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } tx_state_e;

  localparam int BAUD_DIV     = 10416;
  localparam int SAMPLE_POINT = 5000;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Receiver-side byte input, Sender-side START/BUSY handshake and queue status.
// master = the surrounding logic, slave = the queue.
interface uart_tx_queue_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0]      RX_DATA;
  logic                   RX_READY;
  logic [DATA_W-1:0]      TX_DATA;
  logic                   TX_START;
  logic                   TX_BUSY;
  logic [$clog2(DEPTH):0] COUNT;
  logic                   FULL;
  logic                   EMPTY;
  logic                   OVERFLOW;

  modport master (
    output RX_DATA, RX_READY, TX_BUSY,
    input  TX_DATA, TX_START, COUNT, FULL, EMPTY, OVERFLOW
  );

  modport slave (
    input  RX_DATA, RX_READY, TX_BUSY,
    output TX_DATA, TX_START, COUNT, FULL, EMPTY, OVERFLOW
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO; head is read combinationally, push while full is
// accepted only when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/uart_tx_queue.sv
// Buffers bytes from the Receiver (one per READY rising edge) and feeds them to
// the Sender one frame at a time over START/BUSY; OVERFLOW is sticky until RST.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input logic            CLK,
  input logic            RST,
  uart_tx_queue_if.slave q
);

  localparam int CW = count_width(DEPTH);

  logic              rdy_q;
  logic              push;
  logic              pop;
  logic              overflow_q;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  tx_state_e         state;
  tx_state_e         state_nxt;

  assign push = q.RX_READY & ~rdy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdy_q      <= 1'b0;
      overflow_q <= 1'b0;
      state      <= IDLE;
    end else begin
      rdy_q <= q.RX_READY;
      if (push & full & ~pop) overflow_q <= 1'b1;
      state <= state_nxt;
    end
  end

  // START is held for the whole LAUNCH state so the Sender's BUSY latency sets its width.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:   if (~empty & ~q.TX_BUSY) state_nxt = LAUNCH;
      LAUNCH: if (q.TX_BUSY) begin
                pop       = 1'b1;
                state_nxt = WAIT;
              end
      WAIT:   if (~q.TX_BUSY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .wr_data (q.RX_DATA),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign q.TX_DATA  = head;
  assign q.TX_START = (state == LAUNCH);
  assign q.COUNT    = count;
  assign q.FULL     = full;
  assign q.EMPTY    = empty;
  assign q.OVERFLOW = overflow_q;

endmodule
